burst_ram_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one BurstRAM port between up to four burst requesters, such as the instruction cache, data cache, a DMA engine and a debug loader. Each command is issued as exactly one BurstRAM burst. The arbiter holds ownership of the RAM for the whole burst and routes read beats and write-data pacing to the owning requester. It sits between the cache/DMA clients and the BurstRAM controller and replaces ad-hoc two-way enable muxing.

---
 rtl/burst_ram_arbiter_pkg.sv | 26 ++
 rtl/rr_picker.sv | 31 +++
 rtl/burst_ram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the BurstRAM round-robin arbiter: one-hot FSM
// state encoding, BurstRAM command codes and the requester-count limit.
package burst_ram_arbiter_pkg;

  // Largest supported number of requesters; sizes every requester index.
  localparam int NUM_REQ_MAX = 4;
  localparam int IDX_W       = $clog2(NUM_REQ_MAX);

  // One-hot state codes.
  localparam logic [3:0] ST_IDLE_OH  = 4'b0001;
  localparam logic [3:0] ST_ISSUE_OH = 4'b0010;
  localparam logic [3:0] ST_BURST_OH = 4'b0100;
  localparam logic [3:0] ST_DRAIN_OH = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE  = ST_IDLE_OH,
    ST_ISSUE = ST_ISSUE_OH,
    ST_BURST = ST_BURST_OH,
    ST_DRAIN = ST_DRAIN_OH
  } state_t;

  // BurstRAM command encoding.
  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after `last`, wrapping modulo NUM_REQ.
module rr_picker
  import burst_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   grant
);

  // Scan last+1, last+2, ... last+NUM_REQ; the first hit wins.
  always_comb begin
    int idx;
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!valid && (j == idx) && req[j]) begin
          valid = 1'b1;
          grant = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one BurstRAM port among up to four
// burst requesters. Each grant issues exactly one burst; the owner keeps
// the RAM until the burst has drained.
// Optional build macro: BURST_RAM_ARB_TIMEOUT_EN adds a BURST/DRAIN
// watchdog that forces the arbiter back to IDLE and raises err_timeout.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ                 = 2,
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int TIMEOUT_CYCLES          = 255
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              req_en,
  input  logic [NUM_REQ-1:0]                              req_cmd,
  input  logic [NUM_REQ*RAM_DEPTH_BITWIDTH-1:0]           req_addr,
  input  logic [NUM_REQ*RAM_BURST_DATA_BITWIDTH-1:0]      req_wr_data,
  input  logic [NUM_REQ*RAM_BURST_DATA_BITWIDTH/8-1:0]    req_data_mask,
  output logic [NUM_REQ-1:0]                              req_ack,
  output logic [NUM_REQ-1:0]                              req_wr_next,
  output logic [NUM_REQ-1:0]                              req_rd_valid,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]              rd_data,
  output logic [NUM_REQ-1:0]                              req_busy,
  output logic                                            err_timeout,
  output logic                                            br_cmd,
  output logic                                            br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]                   br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]              br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]            br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]              br_rd_data,
  input  logic                                            br_rd_data_valid,
  input  logic                                            br_busy
);

  localparam int D      = RAM_DEPTH_BITWIDTH;
  localparam int W      = RAM_BURST_DATA_BITWIDTH;
  localparam int M      = W / 8;
  localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                cmd_q, cmd_d;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                timeout_hit;

  logic [NUM_REQ-1:0]  owner_oh;
  logic                own_cmd;
  logic [D-1:0]        own_addr;
  logic [W-1:0]        own_wr_data;
  logic [M-1:0]        own_mask;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
    .req   (req_en),
    .last  (last_grant_q),
    .valid (pick_valid),
    .grant (pick_idx)
  );

  // Select the current owner's command slices.
  always_comb begin
    owner_oh    = '0;
    own_cmd     = BR_CMD_READ;
    own_addr    = '0;
    own_wr_data = '0;
    own_mask    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_oh[i] = 1'b1;
        own_cmd     = req_cmd[i];
        own_addr    = req_addr[i*D +: D];
        own_wr_data = req_wr_data[i*W +: W];
        own_mask    = req_data_mask[i*M +: M];
      end
    end
  end

  // Read data is a plain broadcast; only req_rd_valid is steered.
  assign rd_data  = br_rd_data;

  // Nobody may be granted during reset, while a burst is in flight, or while the RAM is busy.
  assign req_busy = {NUM_REQ{rst || (state_q != ST_IDLE) || br_busy}};

  // Next-state logic and BurstRAM/requester strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    cmd_d        = cmd_q;
    br_cmd_en    = 1'b0;
    br_cmd       = BR_CMD_READ;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    req_ack      = '0;
    req_wr_next  = '0;
    req_rd_valid = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!br_busy && pick_valid) begin
          owner_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        br_cmd_en    = 1'b1;
        br_cmd       = own_cmd;
        br_addr      = own_addr;
        br_wr_data   = own_wr_data;
        br_data_mask = own_mask;
        req_ack      = owner_oh;
        cmd_d        = own_cmd;
        beat_cnt_d   = '0;
        state_d      = ST_BURST;
      end
      ST_BURST: begin
        if (cmd_q == BR_CMD_WRITE) begin
          // Beat k is on the owner's slice during BURST cycle k; the pulse asks for beat k+1.
          br_wr_data   = own_wr_data;
          br_data_mask = own_mask;
          if (beat_cnt_q != LAST_BEAT) begin
            req_wr_next = owner_oh;
            beat_cnt_d  = beat_cnt_q + 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (br_rd_data_valid) begin
          req_rd_valid = owner_oh;
          if (beat_cnt_q == LAST_BEAT) state_d = ST_DRAIN;
          else                         beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!br_busy) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stuck burst is abandoned and the rotation moves past its owner.
    if (timeout_hit) begin
      state_d      = ST_IDLE;
      last_grant_d = owner_q;
    end
  end

  // State, ownership and beat-tracking registers.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      cmd_q        <= BR_CMD_READ;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      cmd_q        <= cmd_d;
    end
  end

`ifdef BURST_RAM_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;
  logic              in_burst;

  assign in_burst    = (state_q == ST_BURST) || (state_q == ST_DRAIN);
  assign timeout_hit = in_burst && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  // Watchdog over BURST/DRAIN time; the error flag stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (timeout_hit) begin
      wdog_q <= '0;
      err_q  <= 1'b1;
    end else if (in_burst) begin
      wdog_q <= wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter (NUM_REQ=2, 4 beats of 64 bits).
// A per-cycle vector table covers reset, a single read, contention and
// rotation; directed sequences cover write pacing, DRAIN hold on br_busy,
// reset mid-burst and the watchdog (when BURST_RAM_ARB_TIMEOUT_EN is set).
module tb_burst_ram_arbiter;

  localparam int N   = 2;
  localparam int D   = 4;
  localparam int W   = 64;
  localparam int M   = W / 8;
  localparam int CNT = 4;
  localparam int TO  = 16;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_en, req_cmd;
  logic [N*D-1:0]   req_addr;
  logic [N*W-1:0]   req_wr_data;
  logic [N*M-1:0]   req_data_mask;
  logic [N-1:0]     req_ack, req_wr_next, req_rd_valid, req_busy;
  logic [W-1:0]     rd_data;
  logic             err_timeout;
  logic             br_cmd, br_cmd_en;
  logic [D-1:0]     br_addr;
  logic [W-1:0]     br_wr_data;
  logic [M-1:0]     br_data_mask;
  logic [W-1:0]     br_rd_data;
  logic             br_rd_data_valid;
  logic             br_busy;

  burst_ram_arbiter #(
    .NUM_REQ(N), .RAM_DEPTH_BITWIDTH(D), .RAM_BURST_DATA_BITWIDTH(W),
    .RAM_BURST_DATA_COUNT(CNT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_data_mask(req_data_mask), .req_ack(req_ack),
    .req_wr_next(req_wr_next), .req_rd_valid(req_rd_valid), .rd_data(rd_data),
    .req_busy(req_busy), .err_timeout(err_timeout), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One table row: inputs for a cycle plus the expected outputs in that cycle.
  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  cmd;
    logic        busy;
    logic        rv;
    logic [63:0] rd;
    logic [78:0] exp;  // {err, cmd_en, cmd, addr, ack, wr_next, rd_valid, busy, rd_data}
  } vec_t;

  vec_t vecs[24];
  int   n_vec = 0;

  task automatic add(input logic r, input logic [1:0] en, input logic [1:0] cmd,
                     input logic bsy_in, input logic rv, input logic [63:0] rd,
                     input logic ce, input logic c, input logic [3:0] a,
                     input logic [1:0] ack, input logic [1:0] wn,
                     input logic [1:0] rvo, input logic [1:0] bsy);
    vecs[n_vec].rst  = r;
    vecs[n_vec].en   = en;
    vecs[n_vec].cmd  = cmd;
    vecs[n_vec].busy = bsy_in;
    vecs[n_vec].rv   = rv;
    vecs[n_vec].rd   = rd;
    vecs[n_vec].exp  = {1'b0, ce, c, a, ack, wn, rvo, bsy, rd};
    n_vec++;
  endtask

  logic [63:0] rb[4];
  logic [63:0] wb[4];
  int          wbeat;
  int          pulses;

  initial begin
    rb[0] = 64'hAAAA_0000_0000_0001; rb[1] = 64'hBBBB_0000_0000_0002;
    rb[2] = 64'hCCCC_0000_0000_0003; rb[3] = 64'hDDDD_0000_0000_0004;
    wb[0] = 64'h1000_0000_0000_00F0; wb[1] = 64'h2000_0000_0000_00F1;
    wb[2] = 64'h3000_0000_0000_00F2; wb[3] = 64'h4000_0000_0000_00F3;

    rst = 1'b1; req_en = '0; req_cmd = '0; br_busy = 1'b0;
    br_rd_data_valid = 1'b0; br_rd_data = '0;
    req_addr      = {4'd3, 4'd5};
    req_wr_data   = {wb[0], 64'h0};
    req_data_mask = {8'hFF, 8'h0F};

    //   rst en    cmd   bsy rv rd                 ce c a     ack   wn    rvo   busy
    add(1, 2'b00, 2'b00, 0, 0, 64'h0,               0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b11); // reset
    add(0, 2'b01, 2'b00, 0, 1, 64'h5555,            0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00); // idle, stray valid ignored
    add(0, 2'b01, 2'b00, 0, 0, 64'h0,               1, 0, 4'd5, 2'b01, 2'b00, 2'b00, 2'b11); // issue req0 read
    add(0, 2'b00, 2'b00, 0, 1, rb[0],               0, 0, 4'd0, 2'b00, 2'b00, 2'b01, 2'b11);
    add(0, 2'b00, 2'b00, 0, 0, 64'hDEAD,            0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b11); // gap
    add(0, 2'b00, 2'b00, 0, 1, rb[1],               0, 0, 4'd0, 2'b00, 2'b00, 2'b01, 2'b11);
    add(0, 2'b00, 2'b00, 0, 1, rb[2],               0, 0, 4'd0, 2'b00, 2'b00, 2'b01, 2'b11);
    add(0, 2'b00, 2'b00, 0, 1, rb[3],               0, 0, 4'd0, 2'b00, 2'b00, 2'b01, 2'b11);
    add(0, 2'b11, 2'b00, 0, 0, 64'h0,               0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b11); // drain
    add(0, 2'b11, 2'b00, 0, 0, 64'h0,               0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00); // idle, both request
    add(0, 2'b11, 2'b00, 0, 0, 64'h0,               1, 0, 4'd3, 2'b10, 2'b00, 2'b00, 2'b11); // req1 wins
    add(0, 2'b01, 2'b00, 0, 1, rb[0],               0, 0, 4'd0, 2'b00, 2'b00, 2'b10, 2'b11);
    add(0, 2'b01, 2'b00, 0, 1, rb[1],               0, 0, 4'd0, 2'b00, 2'b00, 2'b10, 2'b11);
    add(0, 2'b01, 2'b00, 0, 1, rb[2],               0, 0, 4'd0, 2'b00, 2'b00, 2'b10, 2'b11);
    add(0, 2'b01, 2'b00, 0, 1, rb[3],               0, 0, 4'd0, 2'b00, 2'b00, 2'b10, 2'b11);
    add(0, 2'b01, 2'b00, 0, 0, 64'h0,               0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b11); // drain
    add(0, 2'b01, 2'b00, 0, 0, 64'h0,               0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00); // idle
    add(0, 2'b01, 2'b00, 0, 0, 64'h0,               1, 0, 4'd5, 2'b01, 2'b00, 2'b00, 2'b11); // req0 again

    for (int i = 0; i < n_vec; i++) begin
      rst              = vecs[i].rst;
      req_en           = vecs[i].en;
      req_cmd          = vecs[i].cmd;
      br_busy          = vecs[i].busy;
      br_rd_data_valid = vecs[i].rv;
      br_rd_data       = vecs[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {err_timeout, br_cmd_en, br_cmd, br_addr, req_ack, req_wr_next, req_rd_valid, req_busy, rd_data},
            vecs[i].exp);
      adv();
    end

    // Write burst from req1 with beat pacing.
    rst = 1'b1; req_en = '0; req_cmd = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
    adv();
    rst = 1'b0; req_en = 2'b10; req_cmd = 2'b10; wbeat = 0; pulses = 0;
    req_wr_data[127:64] = wb[0];
    @(negedge clk);
    check("wr_idle_busy", req_busy, 2'b00);
    adv();
    @(negedge clk);
    check("wr_issue", {br_cmd_en, br_cmd, br_addr, req_ack, br_wr_data, br_data_mask},
          {1'b1, 1'b1, 4'd3, 2'b10, wb[0], 8'hFF});
    adv();
    req_en = 2'b00;
    br_rd_data_valid = 1'b1;  // must be ignored during a write
    for (int k = 0; k < CNT; k++) begin
      req_wr_data[127:64] = wb[wbeat];
      @(negedge clk);
      check($sformatf("wr_beat%0d", k), {br_wr_data, br_data_mask, req_rd_valid}, {wb[k], 8'hFF, 2'b00});
      check($sformatf("wr_next%0d", k), req_wr_next, (k < CNT - 1) ? 2'b10 : 2'b00);
      if (req_wr_next[1]) begin
        pulses++;
        if (wbeat < CNT - 1) wbeat++;
      end
      adv();
    end
    br_rd_data_valid = 1'b0;
    check("wr_next_count", pulses, 3);

    // DRAIN held by br_busy for 10 cycles while req0 waits.
    br_busy = 1'b1; req_en = 2'b01; req_cmd = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("busy_hold%0d", c), {br_cmd_en, req_busy}, {1'b0, 2'b11});
      adv();
    end
    br_busy = 1'b0;
    @(negedge clk);
    check("drain_exit", {br_cmd_en, req_busy}, {1'b0, 2'b11});
    adv();
    @(negedge clk);
    check("idle_after_busy", {br_cmd_en, req_busy}, {1'b0, 2'b00});
    adv();
    @(negedge clk);
    check("issue_after_busy", {br_cmd_en, br_cmd, br_addr, req_ack}, {1'b1, 1'b0, 4'd5, 2'b01});
    adv();
    req_en = 2'b00;
    for (int k = 0; k < CNT; k++) begin
      br_rd_data_valid = 1'b1; br_rd_data = rb[k];
      @(negedge clk);
      check($sformatf("rd0_beat%0d", k), {req_rd_valid, rd_data}, {2'b01, rb[k]});
      adv();
    end
    br_rd_data_valid = 1'b0;
    adv();  // drain; req0 now holds last grant

    // req1 read, reset during beat 2.
    req_en = 2'b10;
    adv();
    @(negedge clk);
    check("rd1_issue", {br_cmd_en, br_addr, req_ack}, {1'b1, 4'd3, 2'b10});
    adv();
    req_en = 2'b00; br_rd_data_valid = 1'b1; br_rd_data = rb[0];
    adv();
    br_rd_data = rb[1];
    adv();
    br_rd_data = rb[2]; rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_busy", req_busy, 2'b11);
    adv();
    rst = 1'b0; br_rd_data_valid = 1'b0; br_rd_data = '0; req_en = 2'b11;
    @(negedge clk);
    check("post_reset",
          {err_timeout, br_cmd_en, br_cmd, br_addr, req_ack, req_wr_next, req_rd_valid, req_busy},
          {1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00, 2'b00, 2'b00});
    adv();
    @(negedge clk);
    check("post_reset_grant", {br_cmd_en, br_addr, req_ack}, {1'b1, 4'd5, 2'b01});
    adv();
    req_en = 2'b00;

    // req0 read with no beats returned.
`ifdef BURST_RAM_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c == TO) check("timeout_not_yet", err_timeout, 1'b0);
      adv();
    end
    @(negedge clk);
    check("timeout_set", {err_timeout, req_busy}, {1'b1, 2'b00});
    adv();
    @(negedge clk);
    check("timeout_sticky", err_timeout, 1'b1);
`else
    for (int c = 0; c < 20; c++) adv();
    @(negedge clk);
    check("no_watchdog", {err_timeout, req_busy}, {1'b0, 2'b11});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
